// File: rtl/regfile.sv
// 32 x WIDTH architectural register file: one synchronous write port, two
// combinational read ports, with one index hardwired to zero.
module regfile #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [31:0]      write_sel;
    logic [31:0]      bit_col [WIDTH];

    // One-hot write decode; the zero register is never selected.
    always_comb begin
        write_sel = '0;
        if (RegWrite) begin
            write_sel[WriteRegister] = 1'b1;
        end
        write_sel[ZERO_IDX] = 1'b0;
    end

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            regs_d[k] = write_sel[k] ? WriteData : regs_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 32; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Transpose so each read port is WIDTH independent 32:1 bit selects.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            for (int k = 0; k < 32; k++) begin
                bit_col[j][k] = regs_q[k][j];
            end
        end
    end

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        for (int j = 0; j < WIDTH; j++) begin
            ReadData1[j] = bit_col[j][ReadRegister1];
            ReadData2[j] = bit_col[j][ReadRegister2];
        end
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end
        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, write/readback, zero
// register, write-enable gating, read-during-write and reset priority.
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks = 0;
    int errors = 0;

    regfile #(.WIDTH(64), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [63:0] data,
                             input logic we);
        @(negedge clk);
        RegWrite      = we;
        WriteRegister = idx;
        WriteData     = data;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [63:0] e1,
                              input logic [63:0] e2);
        @(negedge clk);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
        check({tag, "_rd1"}, ReadData1, e1);
        check({tag, "_rd2"}, ReadData2, e2);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;

        // Reset then read every index on both ports.
        pulse_reset();
        for (int k = 0; k < 32; k++) begin
            read_check($sformatf("reset_sweep_%0d", k), 5'(k), 5'(31 - k), 64'h0, 64'h0);
        end

        // Write 0x100+k into registers 0..30, read back crosswise.
        for (int k = 0; k < 31; k++) begin
            write_reg(5'(k), 64'h100 + 64'(k), 1'b1);
        end
        for (int k = 0; k < 31; k++) begin
            read_check($sformatf("readback_%0d", k), 5'(k), 5'(30 - k),
                       64'h100 + 64'(k), 64'h100 + 64'(30 - k));
        end
        read_check("spot_5_25", 5'd5, 5'd25, 64'h105, 64'h119);

        // Writes to the zero register are discarded.
        write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        read_check("zero_reg", 5'd31, 5'd30, 64'h0, 64'h11E);
        read_check("zero_reg_both", 5'd31, 5'd31, 64'h0, 64'h0);

        // RegWrite=0 must not modify anything.
        write_reg(5'd3, 64'hDEAD_BEEF_0000_0000, 1'b0);
        read_check("we_gating", 5'd3, 5'd3, 64'h103, 64'h103);

        // Read-during-write: old value before the edge, new value after.
        @(negedge clk);
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("rdw_before_rd1", ReadData1, 64'h107);
        check("rdw_before_rd2", ReadData2, 64'h107);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        check("rdw_after_rd1", ReadData1, 64'h1234_5678_9ABC_DEF0);
        check("rdw_after_rd2", ReadData2, 64'h1234_5678_9ABC_DEF0);

        // Reset wins over a simultaneous write.
        read_check("pre_reset_10", 5'd10, 5'd8, 64'h10A, 64'h108);
        @(negedge clk);
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd10;
        WriteData     = 64'hAAAA_AAAA_AAAA_AAAA;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        RegWrite = 1'b0;
        read_check("reset_prio_10", 5'd10, 5'd10, 64'h0, 64'h0);
        for (int k = 0; k < 32; k++) begin
            read_check($sformatf("post_reset_%0d", k), 5'(k), 5'(31 - k), 64'h0, 64'h0);
        end

        // A write after mid-program reset still lands normally.
        write_reg(5'd12, 64'h0F0F_0000_FFFF_1234, 1'b1);
        read_check("post_reset_write", 5'd12, 5'd13, 64'h0F0F_0000_FFFF_1234, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
